// File: rtl/obstacle_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_scheduler_if
//  Description : Spawn-offer handshake between the obstacle scheduler and the
//                obstacle engine.
//                  spawn_valid   scheduler -> engine  offer present
//                  spawn_ready   engine -> scheduler  offer accepted
//                  spawn_type    scheduler -> engine  0 small, 1 large, 2 bird
//                  spawn_height  scheduler -> engine  bird height 0..2
//  Revision    : 1.0  initial release
// ============================================================================
interface obstacle_scheduler_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [1:0] spawn_type;
  logic [1:0] spawn_height;

  modport master (
    output spawn_valid,
    output spawn_type,
    output spawn_height,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_type,
    input  spawn_height,
    output spawn_ready
  );
endinterface
`default_nettype wire

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_scheduler
//  Description : Obstacle spawn controller for the dino game. Counts frame
//                ticks between spawns, draws obstacle kind/height and the next
//                gap from the LFSR byte, and offers each spawn over a
//                valid/ready handshake. Gaps shrink as the level rises.
//  Ports       : clk           system clock
//                rst_n         asynchronous active-low reset
//                i_tick        one-cycle game-frame pulse
//                i_run         high while the game runs
//                i_rnd         LFSR byte, sampled in DRAW
//                spawn_if      master side of the spawn handshake
//                o_spawn_count accepted spawns since start, saturating at 255
//                o_level       min(spawn_count[7:3], LEVEL_MAX)
//  Revision    : 1.0  initial release
// ============================================================================
module obstacle_scheduler #(
  parameter int unsigned FIRST_GAP = 30,
  parameter int unsigned GAP_MIN   = 40,
  parameter int unsigned GAP_FLOOR = 20,
  parameter int unsigned LEVEL_MAX = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_tick,
  input  logic                        i_run,
  input  logic [7:0]                  i_rnd,
  obstacle_scheduler_if.master        spawn_if,
  output logic [7:0]                  o_spawn_count,
  output logic [4:0]                  o_level
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WAIT  = 2'd1;
  localparam logic [1:0] c_ST_DRAW  = 2'd2;
  localparam logic [1:0] c_ST_OFFER = 2'd3;

  localparam logic [7:0] c_FIRST_GAP = 8'(FIRST_GAP);
  localparam logic [8:0] c_GAP_MIN   = 9'(GAP_MIN);
  localparam logic [8:0] c_FLOOR9    = 9'(GAP_FLOOR);
  localparam logic [7:0] c_FLOOR8    = 8'(GAP_FLOOR);
  localparam logic [4:0] c_LEVEL_MAX = 5'(LEVEL_MAX);

  logic [1:0] r_state, w_state_nxt;
  logic [7:0] r_gap_cnt, w_gap_nxt;
  logic [7:0] r_next_gap, w_next_gap_nxt;
  logic       r_last_bird, w_last_bird_nxt;
  logic       r_valid, w_valid_nxt;
  logic [1:0] r_type, w_type_nxt;
  logic [1:0] r_height, w_height_nxt;
  logic [7:0] r_count, w_count_nxt;
  logic [4:0] r_level, w_level_nxt;

  logic       w_accept;
  logic [1:0] w_draw_type;
  logic [1:0] w_draw_height;
  logic [8:0] w_s;
  logic [8:0] w_lvl9;
  logic [7:0] w_draw_gap;
  logic [7:0] w_count_inc;
  logic [4:0] w_level_inc;

  assign w_accept = r_valid & spawn_if.spawn_ready;

  // Draw decode: a bird right after a bird becomes a small cactus, and only
  // birds carry a height (code 3 folds onto the lowest height).
  always_comb begin
    case (i_rnd[1:0])
      2'd2:    w_draw_type = 2'd1;
      2'd3:    w_draw_type = r_last_bird ? 2'd0 : 2'd2;
      default: w_draw_type = 2'd0;
    endcase
    w_draw_height = ((w_draw_type == 2'd2) && (i_rnd[3:2] != 2'd3)) ? i_rnd[3:2] : 2'd0;
  end

  // Gap shortening; comparing s against level+floor avoids wrap when the
  // level exceeds the base gap.
  assign w_s        = c_GAP_MIN + {4'd0, i_rnd[7:4], 1'b0};
  assign w_lvl9     = {4'd0, r_level};
  assign w_draw_gap = (w_s < (w_lvl9 + c_FLOOR9)) ? c_FLOOR8 : 8'(w_s - w_lvl9);

  assign w_count_inc = (r_count == 8'hFF) ? r_count : (r_count + 8'd1);
  assign w_level_inc = (w_count_inc[7:3] > c_LEVEL_MAX) ? c_LEVEL_MAX : w_count_inc[7:3];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a falling run overrides tick and handshake
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_ST_IDLE) begin
      if (i_run) w_state_nxt = c_ST_WAIT;
    end else if (!i_run) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_WAIT:  if (i_tick && (r_gap_cnt == 8'd1)) w_state_nxt = c_ST_DRAW;
        c_ST_DRAW:  w_state_nxt = c_ST_OFFER;
        c_ST_OFFER: if (w_accept) w_state_nxt = c_ST_WAIT;
        default:    w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    w_gap_nxt       = r_gap_cnt;
    w_next_gap_nxt  = r_next_gap;
    w_last_bird_nxt = r_last_bird;
    w_valid_nxt     = r_valid;
    w_type_nxt      = r_type;
    w_height_nxt    = r_height;
    w_count_nxt     = r_count;
    w_level_nxt     = r_level;
    if (r_state == c_ST_IDLE) begin
      w_valid_nxt = 1'b0;
      if (i_run) begin
        w_count_nxt     = 8'd0;
        w_level_nxt     = 5'd0;
        w_last_bird_nxt = 1'b0;
        w_gap_nxt       = c_FIRST_GAP;
      end
    end else if (!i_run) begin
      // Count and level are kept for the score display until restart
      w_gap_nxt   = 8'd0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        c_ST_WAIT: begin
          if (i_tick) w_gap_nxt = r_gap_cnt - 8'd1;
        end
        c_ST_DRAW: begin
          w_type_nxt     = w_draw_type;
          w_height_nxt   = w_draw_height;
          w_next_gap_nxt = w_draw_gap;
          w_valid_nxt    = 1'b1;
        end
        c_ST_OFFER: begin
          if (w_accept) begin
            w_gap_nxt       = r_next_gap;
            w_count_nxt     = w_count_inc;
            w_level_nxt     = w_level_inc;
            w_last_bird_nxt = (r_type == 2'd2);
            w_valid_nxt     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt   <= 8'd0;
      r_next_gap  <= 8'd0;
      r_last_bird <= 1'b0;
      r_valid     <= 1'b0;
      r_type      <= 2'd0;
      r_height    <= 2'd0;
      r_count     <= 8'd0;
      r_level     <= 5'd0;
    end else begin
      r_gap_cnt   <= w_gap_nxt;
      r_next_gap  <= w_next_gap_nxt;
      r_last_bird <= w_last_bird_nxt;
      r_valid     <= w_valid_nxt;
      r_type      <= w_type_nxt;
      r_height    <= w_height_nxt;
      r_count     <= w_count_nxt;
      r_level     <= w_level_nxt;
    end
  end

  assign spawn_if.spawn_valid  = r_valid;
  assign spawn_if.spawn_type   = r_type;
  assign spawn_if.spawn_height = r_height;
  assign o_spawn_count         = r_count;
  assign o_level               = r_level;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obstacle_scheduler
//  Description : Directed self-checking bench for obstacle_scheduler. One
//                instance with default parameters, one with GAP_MIN=20 and
//                GAP_FLOOR=20 for the floor and saturation cases. Tick is
//                held high so every cycle is a frame tick; a gap of G ticks
//                shows as spawn_valid rising G+1 edges after acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_obstacle_scheduler;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       run1  = 1'b0;
  logic       run2  = 1'b0;
  logic [7:0] rnd   = 8'd0;
  logic [7:0] cnt1, cnt2;
  logic [4:0] lvl1, lvl2;

  int n_tests = 0;
  int n_fail  = 0;

  obstacle_scheduler_if if1 ();
  obstacle_scheduler_if if2 ();

  obstacle_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (tick),
    .i_run        (run1),
    .i_rnd        (rnd),
    .spawn_if     (if1.master),
    .o_spawn_count(cnt1),
    .o_level      (lvl1)
  );

  obstacle_scheduler #(.GAP_MIN(20), .GAP_FLOOR(20)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (tick),
    .i_run        (run2),
    .i_rnd        (rnd),
    .spawn_if     (if2.master),
    .o_spawn_count(cnt2),
    .o_level      (lvl2)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until spawn_valid is seen high; -1 if the bound expires.
  task automatic wait_valid(input bit sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((sel ? if2.spawn_valid : if1.spawn_valid) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic accept(input bit sel);
    if (sel) if2.spawn_ready = 1'b1;
    else     if1.spawn_ready = 1'b1;
    step();
    if1.spawn_ready = 1'b0;
    if2.spawn_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if ({if1.spawn_valid, if1.spawn_type, if1.spawn_height, cnt1, lvl1} !== 18'd0)
      $display("FAIL reset_dut1: got %b required 0",
               {if1.spawn_valid, if1.spawn_type, if1.spawn_height, cnt1, lvl1});
    n_tests++;
    if ({if2.spawn_valid, if2.spawn_type, if2.spawn_height, cnt2, lvl2} !== 18'd0)
      $display("FAIL reset_dut2: got %b required 0",
               {if2.spawn_valid, if2.spawn_type, if2.spawn_height, cnt2, lvl2});
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int n;
    rnd  = 8'h00;
    tick = 1'b1;
    run1 = 1'b1;
    step();
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 31) begin n_fail++; $display("FAIL first_spawn_latency: got %0d required 31", n); end
    n_tests++;
    if ({if1.spawn_type, if1.spawn_height} !== 4'b0000) begin
      n_fail++; $display("FAIL basic_kind: got type %0d height %0d required 0 0", if1.spawn_type, if1.spawn_height);
    end
    accept(1'b0);
    n_tests++;
    if (if1.spawn_valid !== 1'b0 || cnt1 !== 8'd1) begin
      n_fail++; $display("FAIL accept1: got valid %b count %0d required 0 1", if1.spawn_valid, cnt1);
    end
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 41) begin n_fail++; $display("FAIL gap40: got %0d required 41", n); end
  endtask

  task automatic test_bird_long();
    int n, bad;
    accept(1'b0);                      // count 2
    rnd = 8'hF7;
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 41 || if1.spawn_type !== 2'd2 || if1.spawn_height !== 2'd1) begin
      n_fail++; $display("FAIL bird_F7: got n %0d type %0d height %0d required 41 2 1", n, if1.spawn_type, if1.spawn_height);
    end
    bad = 0;
    repeat (10) begin
      step();
      if (if1.spawn_valid !== 1'b1 || if1.spawn_type !== 2'd2 || if1.spawn_height !== 2'd1) bad++;
    end
    n_tests++;
    if (bad !== 0 || cnt1 !== 8'd2) begin
      n_fail++; $display("FAIL hold_stable: got %0d unstable cycles count %0d required 0 2", bad, cnt1);
    end
    rnd = 8'h00;
    accept(1'b0);                      // count 3, last spawn was a bird
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 71) begin n_fail++; $display("FAIL gap70: got %0d required 71", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    accept(1'b0);                      // count 4, last_bird cleared
    rnd = 8'h0F;
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 41 || if1.spawn_type !== 2'd2 || if1.spawn_height !== 2'd0) begin
      n_fail++; $display("FAIL bird_0F: got n %0d type %0d height %0d required 41 2 0", n, if1.spawn_type, if1.spawn_height);
    end
    accept(1'b0);                      // count 5
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 41 || if1.spawn_type !== 2'd0 || if1.spawn_height !== 2'd0) begin
      n_fail++; $display("FAIL forced_cactus: got n %0d type %0d height %0d required 41 0 0", n, if1.spawn_type, if1.spawn_height);
    end
    rnd = 8'h00;
    accept(1'b0);                      // count 6
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 41) begin n_fail++; $display("FAIL gap_after_pair: got %0d required 41", n); end
  endtask

  task automatic test_level();
    int n;
    accept(1'b0);                      // count 7
    wait_valid(1'b0, 200, n);
    accept(1'b0);                      // count 8
    n_tests++;
    if (lvl1 !== 5'd1 || cnt1 !== 8'd8) begin
      n_fail++; $display("FAIL level1: got level %0d count %0d required 1 8", lvl1, cnt1);
    end
    wait_valid(1'b0, 200, n);          // gap drawn at level 0
    n_tests++;
    if (n !== 41) begin n_fail++; $display("FAIL gap_level0: got %0d required 41", n); end
    accept(1'b0);                      // count 9
    wait_valid(1'b0, 200, n);          // gap drawn at level 1
    n_tests++;
    if (n !== 40) begin n_fail++; $display("FAIL gap39: got %0d required 40", n); end
  endtask

  task automatic test_run_drop();
    int n, bad;
    run1 = 1'b0;
    if1.spawn_ready = 1'b1;
    step();
    if1.spawn_ready = 1'b0;
    n_tests++;
    if (if1.spawn_valid !== 1'b0 || cnt1 !== 8'd9 || lvl1 !== 5'd1) begin
      n_fail++; $display("FAIL run_drop: got valid %b count %0d level %0d required 0 9 1", if1.spawn_valid, cnt1, lvl1);
    end
    bad = 0;
    repeat (60) begin
      step();
      if (if1.spawn_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0 || cnt1 !== 8'd9) begin
      n_fail++; $display("FAIL idle_hold: got %0d valid cycles count %0d required 0 9", bad, cnt1);
    end
    run1 = 1'b1;
    step();
    n_tests++;
    if (cnt1 !== 8'd0 || lvl1 !== 5'd0) begin
      n_fail++; $display("FAIL restart_clear: got count %0d level %0d required 0 0", cnt1, lvl1);
    end
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 31) begin n_fail++; $display("FAIL restart_latency: got %0d required 31", n); end
  endtask

  task automatic test_async_reset();
    int n;
    accept(1'b0);                      // count 1
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if1.spawn_valid, if1.spawn_type, if1.spawn_height, cnt1, lvl1} !== 18'd0) begin
      n_fail++; $display("FAIL async_reset: got %b required 0",
                         {if1.spawn_valid, if1.spawn_type, if1.spawn_height, cnt1, lvl1});
    end
    #2;
    rst_n = 1'b1;
    step();
    wait_valid(1'b0, 200, n);
    n_tests++;
    if (n !== 31 || cnt1 !== 8'd0) begin
      n_fail++; $display("FAIL post_reset_spawn: got n %0d count %0d required 31 0", n, cnt1);
    end
  endtask

  task automatic test_floor_saturation();
    int n, bad;
    rnd  = 8'h00;
    run2 = 1'b1;
    step();
    wait_valid(1'b1, 200, n);
    n_tests++;
    if (n !== 31) begin n_fail++; $display("FAIL dut2_first: got %0d required 31", n); end
    bad = 0;
    for (int k = 1; k <= 128; k++) begin
      accept(1'b1);
      if (k < 128) begin
        wait_valid(1'b1, 100, n);
        if (n !== 21) bad++;
      end
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL gap20_run: got %0d wrong gaps required 0", bad); end
    n_tests++;
    if (cnt2 !== 8'd128 || lvl2 !== 5'd15) begin
      n_fail++; $display("FAIL level_cap: got count %0d level %0d required 128 15", cnt2, lvl2);
    end
    wait_valid(1'b1, 100, n);
    n_tests++;
    if (n !== 21) begin n_fail++; $display("FAIL gap_floor: got %0d required 21", n); end
    for (int k = 129; k <= 300; k++) begin
      accept(1'b1);
      if (k < 300) wait_valid(1'b1, 100, n);
    end
    n_tests++;
    if (cnt2 !== 8'd255 || lvl2 !== 5'd15) begin
      n_fail++; $display("FAIL count_saturate: got count %0d level %0d required 255 15", cnt2, lvl2);
    end
  endtask

  initial begin
    if1.spawn_ready = 1'b0;
    if2.spawn_ready = 1'b0;
    test_reset();
    test_basic();
    test_bird_long();
    test_back_to_back();
    test_level();
    test_run_drop();
    test_async_reset();
    test_floor_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
